// File: rtl/alu_input_pkg.sv
// Shared constants, FSM encoding and sizing helper for the ALU input sequencer.
package alu_input_pkg;

  localparam int IDX_A  = 0;
  localparam int IDX_B  = 1;
  localparam int IDX_OP = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    VALID   = 1'b1
  } state_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-FF synchroniser, stable-level debounce, registered one-cycle rise pulse.
module button_debounce
  import alu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Synchronise, debounce and emit a registered pulse on an accepted rising level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (sync2 != stable) begin
        // Level is accepted only after it has differed for DEBOUNCE_CYCLES cycles.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt    <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_input_seq.sv
// Button-driven operand/opcode loader with collect/valid handshake.
// Optional macro ALU_IN_SIGN_EXT_EN sign-extends A and B instead of zero-extending.
module alu_input_seq
  import alu_input_pkg::*;
#(
  parameter int N_SW            = 14,
  parameter int N_OP            = 6,
  parameter int N_OPERANDS      = 4,
  parameter int N_DATA          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [N_SW-1:0]   i_sw,
  input  logic              i_button_A,
  input  logic              i_button_B,
  input  logic              i_button_Op,
  input  logic              i_ack,
  output logic [N_DATA-1:0] o_alu_A,
  output logic [N_DATA-1:0] o_alu_B,
  output logic [N_OP-1:0]   o_alu_Op,
  output logic [2:0]        o_loaded,
  output logic              o_valid
);

  logic [2:0]            load;
  logic [N_OPERANDS-1:0] field_a;
  logic [N_OPERANDS-1:0] field_b;
  logic [N_OP-1:0]       field_op;
  logic [N_DATA-1:0]     ext_a;
  logic [N_DATA-1:0]     ext_b;
  state_t                state;
  state_t                state_n;
  logic [2:0]            loaded_n;
  logic                  valid_n;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clock(i_clock), .reset(i_reset), .button(i_button_A),  .pulse(load[IDX_A])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clock(i_clock), .reset(i_reset), .button(i_button_B),  .pulse(load[IDX_B])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
    .clock(i_clock), .reset(i_reset), .button(i_button_Op), .pulse(load[IDX_OP])
  );

  assign field_a  = i_sw[N_OPERANDS-1:0];
  assign field_b  = i_sw[2*N_OPERANDS-1:N_OPERANDS];
  assign field_op = i_sw[N_SW-1:N_SW-N_OP];

`ifdef ALU_IN_SIGN_EXT_EN
  assign ext_a = N_DATA'($signed(field_a));
  assign ext_b = N_DATA'($signed(field_b));
`else
  assign ext_a = N_DATA'(field_a);
  assign ext_b = N_DATA'(field_b);
`endif

  // Next-state and next flag values for the collect/valid handshake.
  always_comb begin
    state_n  = state;
    loaded_n = o_loaded;
    valid_n  = o_valid;
    case (state)
      COLLECT: begin
        loaded_n = o_loaded | load;
        if (loaded_n == 3'b111) begin
          state_n = VALID;
          valid_n = 1'b1;
        end else begin
          valid_n = 1'b0;
        end
      end
      VALID: begin
        // An ack that coincides with a load keeps only the freshly loaded field.
        if (i_ack) begin
          loaded_n = load;
          state_n  = COLLECT;
          valid_n  = 1'b0;
        end else begin
          loaded_n = o_loaded | load;
          valid_n  = 1'b1;
        end
      end
      default: begin
        state_n  = COLLECT;
        loaded_n = 3'b000;
        valid_n  = 1'b0;
      end
    endcase
  end

  // State, flags and data capture; data survives ack and only changes on a load.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= COLLECT;
      o_loaded <= 3'b000;
      o_valid  <= 1'b0;
      o_alu_A  <= '0;
      o_alu_B  <= '0;
      o_alu_Op <= '0;
    end else begin
      state    <= state_n;
      o_loaded <= loaded_n;
      o_valid  <= valid_n;
      if (load[IDX_A])  o_alu_A  <= ext_a;
      if (load[IDX_B])  o_alu_B  <= ext_b;
      if (load[IDX_OP]) o_alu_Op <= field_op;
    end
  end

endmodule

// File: tb/tb_alu_input_seq.sv
// Directed, table-driven bench for alu_input_seq with DEBOUNCE_CYCLES=4 (load lands at edge 7).
module tb_alu_input_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] sw;
  logic        btn_a, btn_b, btn_op, ack;
  logic [7:0]  alu_a, alu_b;
  logic [5:0]  alu_op;
  logic [2:0]  loaded;
  logic        valid;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]  mask;
    logic [13:0] sw;
    int          hold;
    logic        ack;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [5:0]  eop;
    logic [2:0]  eld;
    logic        ev;
  } vec_t;

  vec_t vecs[8];

  alu_input_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_sw(sw),
    .i_button_A(btn_a), .i_button_B(btn_b), .i_button_Op(btn_op), .i_ack(ack),
    .o_alu_A(alu_a), .o_alu_B(alu_b), .o_alu_Op(alu_op),
    .o_loaded(loaded), .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [5:0] eop, input logic [2:0] eld, input logic ev);
    chk({name, ".A"},      {24'd0, alu_a},  {24'd0, ea});
    chk({name, ".B"},      {24'd0, alu_b},  {24'd0, eb});
    chk({name, ".Op"},     {26'd0, alu_op}, {26'd0, eop});
    chk({name, ".loaded"}, {29'd0, loaded}, {29'd0, eld});
    chk({name, ".valid"},  {31'd0, valid},  {31'd0, ev});
  endtask

  task automatic set_btns(input logic [2:0] m);
    btn_a  = m[0];
    btn_b  = m[1];
    btn_op = m[2];
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].ack) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
    end else begin
      sw = vecs[i].sw;
      set_btns(vecs[i].mask);
      for (int c = 0; c < 8; c++) begin
        tick();
        if (c == vecs[i].hold - 1) set_btns(3'b000);
      end
    end
    chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].eld, vecs[i].ev);
    set_btns(3'b000);
    repeat (8) tick();
  endtask

  initial begin
    logic [7:0] exp_c;
`ifdef ALU_IN_SIGN_EXT_EN
    exp_c = 8'hFC;
`else
    exp_c = 8'h0C;
`endif
    //          mask    sw        hold ack   A      B      Op     loaded  valid
    vecs[0] = '{3'b010, 14'h0050, 3,  1'b0, 8'h0A, 8'h00, 6'h00, 3'b001, 1'b0};
    vecs[1] = '{3'b001, 14'h0003, 12, 1'b0, 8'h03, 8'h00, 6'h00, 3'b001, 1'b0};
    vecs[2] = '{3'b010, 14'h0050, 12, 1'b0, 8'h03, 8'h05, 6'h00, 3'b011, 1'b0};
    vecs[3] = '{3'b100, 14'h2000, 12, 1'b0, 8'h03, 8'h05, 6'h20, 3'b111, 1'b1};
    vecs[4] = '{3'b000, 14'h0000, 0,  1'b1, 8'h03, 8'h05, 6'h20, 3'b000, 1'b0};
    vecs[5] = '{3'b001, 14'h0007, 12, 1'b0, 8'h07, 8'h05, 6'h20, 3'b001, 1'b0};
    vecs[6] = '{3'b110, 14'h1120, 12, 1'b0, 8'h07, 8'h02, 6'h11, 3'b111, 1'b1};
    vecs[7] = '{3'b001, 14'h000C, 12, 1'b0, exp_c, 8'h09, 6'h11, 3'b011, 1'b0};

    rst = 1'b1;
    sw  = 14'h3FFF;
    ack = 1'b0;
    set_btns(3'b000);
    tick();
    tick();
    chk_all("reset", 8'h00, 8'h00, 6'h00, 3'b000, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // Latency and single-load check: press before edge 0, visible from edge 7.
    sw    = 14'h000A;
    btn_a = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("lat_A_e%0d", e), {24'd0, alu_a}, (e >= 7) ? 32'h0A : 32'h00);
      chk($sformatf("lat_ld_e%0d", e), {29'd0, loaded}, (e >= 7) ? 32'h1 : 32'h0);
      if (e == 8) sw = 14'h0035;
    end
    btn_a = 1'b0;
    repeat (8) tick();

    for (int i = 0; i < 7; i++) apply_vec(i);

    // In VALID, ack in the same cycle as the B load pulse.
    sw    = 14'h0090;
    btn_b = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 6) ack = 1'b1;
      if (e == 7) ack = 1'b0;
    end
    chk_all("ack_load", 8'h07, 8'h09, 6'h11, 3'b010, 1'b0);
    btn_b = 1'b0;
    repeat (8) tick();
    chk_all("ack_load_hold", 8'h07, 8'h09, 6'h11, 3'b010, 1'b0);

    apply_vec(7);

    // Ack while collecting has no effect.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk_all("ack_collect", exp_c, 8'h09, 6'h11, 3'b011, 1'b0);

    // Reset mid-debounce with the button released during reset: no load afterwards.
    sw    = 14'h0005;
    btn_a = 1'b1;
    repeat (3) tick();
    rst   = 1'b1;
    btn_a = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk_all("rst_mid", 8'h00, 8'h00, 6'h00, 3'b000, 1'b0);

    // Button held through reset release counts as a fresh press.
    rst   = 1'b1;
    tick();
    sw    = 14'h0006;
    btn_a = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("held_A_e%0d", e), {24'd0, alu_a}, (e == 7) ? 32'h06 : 32'h00);
    end
    chk("held_ld", {29'd0, loaded}, 32'h1);
    btn_a = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
